// File: rtl/acelp_pulse_pack.sv
`default_nettype none
// ============================================================================
//  Module      : acelp_pulse_pack
//  Description : Scans a 40-sample algebraic code vector in scratch memory,
//                locates the four track pulses and packs their positions into
//                the 13-bit G.729 index and their polarities into a 4-bit
//                sign word. Both words are written back to scratch memory and
//                held on output ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module acelp_pulse_pack #(
    parameter logic [11:0] COD       = 12'h0C0,
    parameter logic [11:0] INDEX_OUT = 12'h100,
    parameter logic [11:0] SIGN_OUT  = 12'h101,
    parameter int          L_SUBFR   = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        done,
    output logic [11:0] scratch_mem_read_addr,
    input  logic [31:0] scratch_mem_in,
    output logic [11:0] scratch_mem_write_addr,
    output logic [31:0] scratch_mem_out,
    output logic        scratch_mem_write_en,
    output logic [12:0] index_out,
    output logic [3:0]  sign_out,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_DRAIN  = 3'd2,
        S_WR_IDX = 3'd3,
        S_WR_SGN = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [5:0] c_last_k = 6'(L_SUBFR - 1);

    state_t          r_state;
    state_t          w_next;
    logic [5:0]      r_k;          // address counter for the scan
    logic            r_eval;       // read data on scratch_mem_in is valid this cycle
    logic [2:0]      r_mod5;       // sample index mod 5 of the word being evaluated
    logic [2:0]      r_div5;       // sample index div 5 of the word being evaluated
    logic [3:0]      r_found;
    logic [3:0]      r_sign;
    logic [3:0][2:0] r_div;        // per-track position / 5
    logic            r_pos3_hi;    // track-3 pulse sits on the mod-5 == 4 sub-track
    logic [1:0]      w_trk;
    logic [12:0]     w_index;
    logic            w_start_ok;

    // Start is accepted only while idle or parked in DONE
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    // Residues 3 and 4 share track 3
    assign w_trk      = (r_mod5 >= 3'd3) ? 2'd3 : r_mod5[1:0];
    assign w_index    = {r_div[3], r_pos3_hi, r_div[2], r_div[1], r_div[0]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and memory-port decode
    always_comb begin
        w_next                 = r_state;
        scratch_mem_read_addr  = 12'h000;
        scratch_mem_write_addr = 12'h000;
        scratch_mem_out        = 32'h0;
        scratch_mem_write_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_READ;
            end
            S_READ: begin
                scratch_mem_read_addr = {COD[11:6], r_k};
                if (r_k == c_last_k) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_next = S_WR_IDX;
            end
            S_WR_IDX: begin
                scratch_mem_write_addr = INDEX_OUT;
                scratch_mem_out        = {19'b0, w_index};
                scratch_mem_write_en   = 1'b1;
                w_next                 = S_WR_SGN;
            end
            S_WR_SGN: begin
                scratch_mem_write_addr = SIGN_OUT;
                scratch_mem_out        = {28'b0, r_sign};
                scratch_mem_write_en   = 1'b1;
                w_next                 = S_DONE;
            end
            S_DONE: begin
                if (start) w_next = S_READ;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Scan counters, per-track pulse capture and codeword legality
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k       <= 6'd0;
            r_eval    <= 1'b0;
            r_mod5    <= 3'd0;
            r_div5    <= 3'd0;
            r_found   <= 4'd0;
            r_sign    <= 4'd0;
            r_div     <= '0;
            r_pos3_hi <= 1'b0;
            error     <= 1'b0;
        end else begin
            r_eval <= (r_state == S_READ);
            if (w_start_ok) begin
                r_k       <= 6'd0;
                r_mod5    <= 3'd0;
                r_div5    <= 3'd0;
                r_found   <= 4'd0;
                r_sign    <= 4'd0;
                r_div     <= '0;
                r_pos3_hi <= 1'b0;
                error     <= 1'b0;
            end else begin
                if (r_state == S_READ) r_k <= r_k + 6'd1;
                if (r_eval) begin
                    if (r_mod5 == 3'd4) begin
                        r_mod5 <= 3'd0;
                        r_div5 <= r_div5 + 3'd1;
                    end else begin
                        r_mod5 <= r_mod5 + 3'd1;
                    end
                    if (scratch_mem_in != 32'h0) begin
                        // First pulse on a track wins; any further one is illegal
                        if (r_found[w_trk]) begin
                            error <= 1'b1;
                        end else begin
                            r_found[w_trk] <= 1'b1;
                            r_div[w_trk]   <= r_div5;
                            r_sign[w_trk]  <= ~scratch_mem_in[31];
                            if (w_trk == 2'd3) r_pos3_hi <= (r_mod5 == 3'd4);
                        end
                    end
                end
                if ((r_state == S_WR_IDX) && (r_found != 4'hF)) error <= 1'b1;
            end
        end
    end

    // Registered result ports and completion flag
    always_ff @(posedge clk) begin
        if (reset) begin
            done      <= 1'b0;
            index_out <= 13'd0;
            sign_out  <= 4'd0;
        end else begin
            if (w_start_ok) begin
                done <= 1'b0;
            end else if (r_state == S_DONE) begin
                done <= 1'b1;
            end
            if (r_state == S_WR_IDX) begin
                index_out <= w_index;
                sign_out  <= r_sign;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_acelp_pulse_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acelp_pulse_pack
//  Description : Self-checking bench for acelp_pulse_pack with directed and
//                randomized code vectors compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acelp_pulse_pack;

    localparam logic [11:0] c_cod   = 12'h0C0;
    localparam logic [11:0] c_idx_a = 12'h100;
    localparam logic [11:0] c_sgn_a = 12'h101;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic [11:0] rd_addr;
    logic [31:0] rd_data;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [12:0] index_out;
    logic [3:0]  sign_out;
    logic        error;

    logic [31:0] vec [40];
    logic [31:0] cap_idx;
    logic [31:0] cap_sgn;
    int          wr_total;
    int          n_chk;
    int          n_err;

    acelp_pulse_pack dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .done                   (done),
        .scratch_mem_read_addr  (rd_addr),
        .scratch_mem_in         (rd_data),
        .scratch_mem_write_addr (wr_addr),
        .scratch_mem_out        (wr_data),
        .scratch_mem_write_en   (wr_en),
        .index_out              (index_out),
        .sign_out               (sign_out),
        .error                  (error)
    );

    always #5 clk = ~clk;

    // Scratch memory: 1-cycle read latency over the code vector, write capture
    always @(posedge clk) begin
        if (rd_addr[11:6] == c_cod[11:6] && rd_addr[5:0] < 6'd40)
            rd_data <= vec[rd_addr[5:0]];
        else
            rd_data <= 32'h0;
        if (wr_en) begin
            wr_total <= wr_total + 1;
            if (wr_addr == c_idx_a) cap_idx <= wr_data;
            else if (wr_addr == c_sgn_a) cap_sgn <= wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: first pulse per track kept, extra or missing pulses are illegal
    task automatic model(output logic [12:0] idx, output logic [3:0] sg, output logic e);
        int d [4];
        bit f [4];
        int hi;
        int t;
        e  = 1'b0;
        sg = 4'd0;
        hi = 0;
        for (int i = 0; i < 4; i++) begin d[i] = 0; f[i] = 0; end
        for (int p = 0; p < 40; p++) begin
            if (vec[p] != 32'h0) begin
                t = (p % 5 >= 3) ? 3 : p % 5;
                if (f[t]) e = 1'b1;
                else begin
                    f[t]  = 1;
                    d[t]  = p / 5;
                    sg[t] = ~vec[p][31];
                    if (t == 3) hi = (p % 5 == 4) ? 1 : 0;
                end
            end
        end
        for (int i = 0; i < 4; i++) if (!f[i]) e = 1'b1;
        idx = 13'(d[0] + d[1] * 8 + d[2] * 64 + hi * 512 + d[3] * 1024);
    endtask

    function automatic logic [31:0] pulse(input bit neg, input int mag);
        return neg ? 32'(-mag) : 32'(mag);
    endfunction

    task automatic clear_vec();
        for (int i = 0; i < 40; i++) vec[i] = 32'h0;
    endtask

    // One pack operation, checked for latency, ports, memory words and strobes
    task automatic run_op(input string tag);
        logic [12:0] e_idx;
        logic [3:0]  e_sg;
        logic        e_err;
        int          cyc;
        int          wr0;
        model(e_idx, e_sg, e_err);
        @(negedge clk);
        wr0   = wr_total;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'd44);
        chk({tag, " index"}, 32'(index_out), 32'(e_idx));
        chk({tag, " sign"}, 32'(sign_out), 32'(e_sg));
        chk({tag, " error"}, 32'(error), 32'(e_err));
        chk({tag, " mem_idx"}, cap_idx, {19'b0, e_idx});
        chk({tag, " mem_sgn"}, cap_sgn, {28'b0, e_sg});
        chk({tag, " strobes"}, 32'(wr_total - wr0), 32'd2);
    endtask

    initial begin
        int p;
        bit illegal;
        n_chk    = 0;
        n_err    = 0;
        wr_total = 0;
        cap_idx  = 32'hDEAD_BEEF;
        cap_sgn  = 32'hDEAD_BEEF;
        reset    = 1'b1;
        start    = 1'b0;
        clear_vec();
        repeat (3) @(posedge clk);
        #1;
        chk("rst done", 32'(done), 32'd0);
        chk("rst index", 32'(index_out), 32'd0);
        chk("rst sign", 32'(sign_out), 32'd0);
        chk("rst error", 32'(error), 32'd0);
        chk("rst wr_en", 32'(wr_en), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Positions 0..3, all positive
        clear_vec();
        for (int i = 0; i < 4; i++) vec[i] = 32'd8191;
        run_op("t1");
        chk("t1 index lit", 32'(index_out), 32'h0000);
        chk("t1 sign lit", 32'(sign_out), 32'hF);

        // Highest positions on every track
        clear_vec();
        vec[35] = 32'd100; vec[36] = pulse(1, 8192); vec[37] = 32'd3; vec[39] = pulse(1, 5);
        run_op("t2");
        chk("t2 index lit", 32'(index_out), 32'h1FFF);
        chk("t2 sign lit", 32'(sign_out), 32'h5);

        clear_vec();
        vec[10] = 32'd7; vec[21] = 32'd9; vec[32] = pulse(1, 1); vec[18] = 32'd4;
        run_op("t3");
        chk("t3 mem lit", cap_idx, 32'h0000_0DA2);
        chk("t3 sgn lit", cap_sgn, 32'h0000_000B);

        // Empty track 2
        clear_vec();
        vec[0] = 32'd1; vec[1] = 32'd1; vec[3] = pulse(1, 2);
        run_op("t4a");
        chk("t4a err lit", 32'(error), 32'd1);

        // Duplicate on track 0: first pulse kept
        clear_vec();
        vec[0] = 32'd1; vec[5] = 32'd1; vec[1] = 32'd1; vec[2] = 32'd1; vec[4] = 32'd1;
        run_op("t4b");
        chk("t4b err lit", 32'(error), 32'd1);
        chk("t4b pos0", 32'(index_out[2:0]), 32'd0);

        // Reset in the middle of a scan suppresses all writes
        @(negedge clk);
        p     = wr_total;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        chk("t5 strobes", 32'(wr_total - p), 32'd0);
        chk("t5 done", 32'(done), 32'd0);
        chk("t5 index", 32'(index_out), 32'd0);
        clear_vec();
        vec[10] = 32'd7; vec[21] = 32'd9; vec[32] = pulse(1, 1); vec[18] = 32'd4;
        run_op("t5 after");

        // Randomized legal and illegal vectors, back-to-back from DONE
        for (int n = 0; n < 40; n++) begin
            clear_vec();
            illegal = ($urandom_range(0, 3) == 0);
            if (!illegal) begin
                for (int t = 0; t < 4; t++) begin
                    p = 5 * $urandom_range(0, 7) + t;
                    if (t == 3) p = p + $urandom_range(0, 1);
                    vec[p] = pulse($urandom_range(0, 1) == 1, $urandom_range(1, 32767));
                end
            end else begin
                for (int j = 0; j < $urandom_range(0, 7); j++)
                    vec[$urandom_range(0, 39)] = pulse($urandom_range(0, 1) == 1,
                                                       $urandom_range(1, 32767));
            end
            run_op($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
